// File: rtl/ram_pl_loader_if.sv
// rtl/ram_pl_loader_if.sv - word stream and RAM preload bus between loader, source and RAM
//
// Signals:
//   S_DATA/S_VALID/S_READY : 32-bit load word stream into the loader
//   PL_INIT/PL_ENA         : init strobe and port enable towards the RAM
//   PL_WEN/PL_REN          : write / read strobes (never both high)
//   PL_ADDR/PL_DATA_IN     : 20-bit address and 32-bit write data
//   PL_DATA_OUT            : read data from the RAM, valid one cycle after PL_REN
// Modports:
//   master : the loader (drives S_READY and the PL outputs)
//   slave  : the word source plus RAM side
interface ram_pl_loader_if;
  logic [31:0] S_DATA;
  logic        S_VALID;
  logic        S_READY;
  logic        PL_INIT;
  logic        PL_ENA;
  logic        PL_WEN;
  logic        PL_REN;
  logic [19:0] PL_ADDR;
  logic [31:0] PL_DATA_IN;
  logic [31:0] PL_DATA_OUT;

  modport master (
    input  S_DATA, S_VALID, PL_DATA_OUT,
    output S_READY, PL_INIT, PL_ENA, PL_WEN, PL_REN, PL_ADDR, PL_DATA_IN
  );

  modport slave (
    output S_DATA, S_VALID, PL_DATA_OUT,
    input  S_READY, PL_INIT, PL_ENA, PL_WEN, PL_REN, PL_ADDR, PL_DATA_IN
  );
endinterface

// File: rtl/ram_pl_loader.sv
// rtl/ram_pl_loader.sv - streams DEPTH words into a RAM through its preload port
//
// Purpose: accepts 32-bit words on bus.S_* and writes them to consecutive
// PL addresses starting at BASE_ADDR. With RAM_PL_VERIFY_EN defined, the
// words are read back afterwards and their sum is compared with the sum of
// the written words; a mismatch sets ERR.
//
// Ports:
//   CLK, RESET_N : clock (also the RAM's PL_CLK) and synchronous active-low reset
//   START        : begin a load, only looked at while idle
//   ABORT        : stop the running load, go idle, set ERR
//   BUSY         : high whenever not idle
//   DONE         : one-cycle pulse at the end of a load
//   ERR          : sticky abort / verify-mismatch flag, cleared by an accepted START
//   bus          : ram_pl_loader_if.master (word stream in, PL bus out)
//
// Build option: RAM_PL_VERIFY_EN enables the read-back verify pass.
module ram_pl_loader #(
  parameter int unsigned DEPTH     = 512,
  parameter logic [19:0] BASE_ADDR = 20'h0
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic               ABORT,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  ram_pl_loader_if.master    bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WRITE,
    ST_DRAIN,
    ST_VERIFY,
    ST_DONE
  } state_t;

  // 11 bits holds DEPTH itself (up to 1024), needed as the verify issue count
  localparam logic [10:0] IDX_LAST = 11'(DEPTH - 1);

  state_t      state_q, state_d;
  logic [10:0] idx_q, idx_d;
  logic [31:0] wsum_q, wsum_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        s_ready_q, s_ready_d;
  logic        pl_init_q, pl_init_d;
  logic        pl_ena_q, pl_ena_d;
  logic        pl_wen_q, pl_wen_d;
  logic [19:0] pl_addr_q, pl_addr_d;
  logic [31:0] pl_data_in_q, pl_data_in_d;

`ifdef RAM_PL_VERIFY_EN
  localparam logic [10:0] IDX_DEPTH = 11'(DEPTH);
  logic        pl_ren_q, pl_ren_d;
  logic        rd_vld_q, rd_vld_d;
  logic [31:0] rsum_q, rsum_d;
  logic        rd_last;
  // final returned word: data is valid this cycle and no read is outstanding
  assign rd_last = (state_q == ST_VERIFY) && rd_vld_q && !pl_ren_q;
`else
  logic unused_pl_data;
  assign unused_pl_data = ^bus.PL_DATA_OUT;
`endif

  logic hs;
  logic abort_now;

  assign hs        = (state_q == ST_WRITE) && bus.S_VALID && s_ready_q;
  assign abort_now = ABORT && (state_q != ST_IDLE);

  // state register
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (abort_now) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (START) state_d = ST_INIT;
        ST_INIT:   state_d = ST_WRITE;
        ST_WRITE:  if (hs && (idx_q == IDX_LAST)) state_d = ST_DRAIN;
`ifdef RAM_PL_VERIFY_EN
        ST_DRAIN:  state_d = ST_VERIFY;
        ST_VERIFY: if (rd_last) state_d = ST_DONE;
`else
        ST_DRAIN:  state_d = ST_DONE;
`endif
        ST_DONE:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // output / datapath logic; every output is a flop loaded from the next state
  always_comb begin
    idx_d        = idx_q;
    wsum_d       = wsum_q;
    err_d        = err_q;
    pl_wen_d     = 1'b0;
    pl_addr_d    = pl_addr_q;
    pl_data_in_d = pl_data_in_q;
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    s_ready_d    = (state_d == ST_WRITE);
    pl_init_d    = (state_d == ST_INIT);
    pl_ena_d     = (state_d inside {ST_INIT, ST_WRITE, ST_DRAIN, ST_VERIFY});
`ifdef RAM_PL_VERIFY_EN
    pl_ren_d     = 1'b0;
    rd_vld_d     = 1'b0;
    rsum_d       = rsum_q;
`endif

    if (abort_now) begin
      // the handshake of this cycle (if any) is dropped with everything else
      err_d        = 1'b1;
      pl_addr_d    = 20'h0;
      pl_data_in_d = 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            err_d  = 1'b0;
            idx_d  = 11'd0;
            wsum_d = 32'h0;
          end
        end
        ST_WRITE: begin
          if (hs) begin
            pl_wen_d     = 1'b1;
            pl_addr_d    = BASE_ADDR + {9'd0, idx_q};
            pl_data_in_d = bus.S_DATA;
            wsum_d       = wsum_q + bus.S_DATA;
            idx_d        = idx_q + 11'd1;
          end
        end
        ST_DRAIN: begin
`ifdef RAM_PL_VERIFY_EN
          // first read is issued on the way into VERIFY, so idx counts issued reads
          rsum_d    = 32'h0;
          pl_ren_d  = 1'b1;
          pl_addr_d = BASE_ADDR;
          idx_d     = 11'd1;
`else
          idx_d     = 11'd0;
`endif
        end
`ifdef RAM_PL_VERIFY_EN
        ST_VERIFY: begin
          rd_vld_d = pl_ren_q;
          if (rd_vld_q) begin
            rsum_d = rsum_q + bus.PL_DATA_OUT;
          end
          if (idx_q < IDX_DEPTH) begin
            pl_ren_d  = 1'b1;
            pl_addr_d = BASE_ADDR + {9'd0, idx_q};
            idx_d     = idx_q + 11'd1;
          end
          if (rd_last && ((rsum_q + bus.PL_DATA_OUT) != wsum_q)) begin
            err_d = 1'b1;
          end
        end
`endif
        ST_DONE: begin
          pl_addr_d    = 20'h0;
          pl_data_in_d = 32'h0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      idx_q        <= 11'd0;
      wsum_q       <= 32'h0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      s_ready_q    <= 1'b0;
      pl_init_q    <= 1'b0;
      pl_ena_q     <= 1'b0;
      pl_wen_q     <= 1'b0;
      pl_addr_q    <= 20'h0;
      pl_data_in_q <= 32'h0;
`ifdef RAM_PL_VERIFY_EN
      pl_ren_q     <= 1'b0;
      rd_vld_q     <= 1'b0;
      rsum_q       <= 32'h0;
`endif
    end else begin
      idx_q        <= idx_d;
      wsum_q       <= wsum_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      s_ready_q    <= s_ready_d;
      pl_init_q    <= pl_init_d;
      pl_ena_q     <= pl_ena_d;
      pl_wen_q     <= pl_wen_d;
      pl_addr_q    <= pl_addr_d;
      pl_data_in_q <= pl_data_in_d;
`ifdef RAM_PL_VERIFY_EN
      pl_ren_q     <= pl_ren_d;
      rd_vld_q     <= rd_vld_d;
      rsum_q       <= rsum_d;
`endif
    end
  end

  assign BUSY           = busy_q;
  assign DONE           = done_q;
  assign ERR            = err_q;
  assign bus.S_READY    = s_ready_q;
  assign bus.PL_INIT    = pl_init_q;
  assign bus.PL_ENA     = pl_ena_q;
  assign bus.PL_WEN     = pl_wen_q;
  assign bus.PL_ADDR    = pl_addr_q;
  assign bus.PL_DATA_IN = pl_data_in_q;
`ifdef RAM_PL_VERIFY_EN
  assign bus.PL_REN     = pl_ren_q;
`else
  assign bus.PL_REN     = 1'b0;
`endif

endmodule

// File: tb/tb_ram_pl_loader.sv
// tb/tb_ram_pl_loader.sv - directed self-checking bench for ram_pl_loader
module tb_ram_pl_loader;
  localparam int          DEPTH = 4;
  localparam logic [19:0] BASE  = 20'h100;
  // cycles from the START cycle to the DONE cycle (DEPTH+4 counting both ends)
`ifdef RAM_PL_VERIFY_EN
  localparam int DONE_LAT = 12;
`else
  localparam int DONE_LAT = 7;
`endif

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic START = 1'b0;
  logic ABORT = 1'b0;
  logic BUSY, DONE, ERR;

  ram_pl_loader_if bus();

  ram_pl_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // RAM model: registered read, optional corruption of one address
  logic [31:0] mem [0:3];
  logic [31:0] rd_q = 32'h0;
  logic [19:0] corrupt_addr = 20'hFFFFF;
  logic [19:0] off;
  assign off = bus.PL_ADDR - BASE;
  always @(posedge CLK) begin
    if (bus.PL_WEN) mem[off[1:0]] <= bus.PL_DATA_IN;
    if (bus.PL_REN) rd_q <= (bus.PL_ADDR == corrupt_addr) ? 32'h0 : mem[off[1:0]];
  end
  assign bus.PL_DATA_OUT = rd_q;

  // bus monitor, cleared whenever clr_gen moves
  int clr_gen = 0;
  int seen_gen = 0;
  int wr_addr[$], wr_data[$], wr_cyc[$], hs_cyc[$], rd_addr[$];
  int init_cnt = 0, init_cyc = -1, ready_cyc = -1, done_cnt = 0, excl_viol = 0;
  always @(negedge CLK) begin
    bit clr;
    clr = (clr_gen != seen_gen);
    if (clr) begin
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
      hs_cyc.delete(); rd_addr.delete();
    end
    seen_gen  <= clr_gen;
    init_cnt  <= (clr ? 0 : init_cnt) + (bus.PL_INIT ? 1 : 0);
    done_cnt  <= (clr ? 0 : done_cnt) + (DONE ? 1 : 0);
    excl_viol <= excl_viol + ((bus.PL_WEN && bus.PL_REN) ? 1 : 0);
    init_cyc  <= (bus.PL_INIT && (clr || init_cyc < 0)) ? cyc : (clr ? -1 : init_cyc);
    ready_cyc <= (bus.S_READY && (clr || ready_cyc < 0)) ? cyc : (clr ? -1 : ready_cyc);
    if (bus.PL_WEN) begin
      wr_addr.push_back(int'(bus.PL_ADDR));
      wr_data.push_back(int'(bus.PL_DATA_IN));
      wr_cyc.push_back(cyc);
    end
    if (bus.PL_REN) rd_addr.push_back(int'(bus.PL_ADDR));
    if (bus.S_VALID && bus.S_READY && !ABORT) hs_cyc.push_back(cyc);
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    clr_gen++;
  endtask

  // drives words 1..n; gap inserts an idle cycle after every accepted word
  task automatic stream_words(input bit gap, input int n);
    int sent = 0;
    int guard = 0;
    bit hs;
    while (sent < n && guard < 60) begin
      bus.S_VALID = 1'b1;
      bus.S_DATA  = 32'(sent + 1);
      hs = bus.S_READY;
      tick();
      guard++;
      if (hs) begin
        sent++;
        if (gap) begin
          bus.S_VALID = 1'b0;
          tick();
        end
      end
    end
    bus.S_VALID = 1'b0;
    chk("stream_accepted", 32'(sent), 32'(n));
  endtask

  task automatic wait_done(output int dc);
    int n = 0;
    while (!DONE && n < 100) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(DONE), 32'd1);
    dc = cyc;
  endtask

  task automatic check_writes(input string tag, input int n);
    chk({tag, "_wr_count"}, 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      chk({tag, "_wr_addr"}, 32'(wr_addr[i]), 32'(BASE) + 32'(i));
      chk({tag, "_wr_data"}, 32'(wr_data[i]), 32'(i + 1));
      if (i < hs_cyc.size()) chk({tag, "_wr_after_hs"}, 32'(wr_cyc[i]), 32'(hs_cyc[i] + 1));
    end
  endtask

  task automatic start_load(output int s);
    clear_logs();
    START = 1'b1;
    s = cyc;
    tick();
    START = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},    32'(BUSY), 32'd0);
    chk({tag, "_done"},    32'(DONE), 32'd0);
    chk({tag, "_sready"},  32'(bus.S_READY), 32'd0);
    chk({tag, "_init"},    32'(bus.PL_INIT), 32'd0);
    chk({tag, "_ena"},     32'(bus.PL_ENA), 32'd0);
    chk({tag, "_wen"},     32'(bus.PL_WEN), 32'd0);
    chk({tag, "_ren"},     32'(bus.PL_REN), 32'd0);
    chk({tag, "_addr"},    32'(bus.PL_ADDR), 32'd0);
    chk({tag, "_data_in"}, 32'(bus.PL_DATA_IN), 32'd0);
  endtask

  initial begin
    int s, dc;
    bus.S_VALID = 1'b0;
    bus.S_DATA  = 32'h0;

    // reset values
    tick();
    tick();
    check_idle_outputs("rst");
    chk("rst_err", 32'(ERR), 32'd0);
    RESET_N = 1'b1;
    tick();

    // back-to-back load of words 1..4
    start_load(s);
    chk("t1_init_pulse", 32'(bus.PL_INIT), 32'd1);
    chk("t1_init_ena",   32'(bus.PL_ENA), 32'd1);
    stream_words(1'b0, DEPTH);
    wait_done(dc);
    chk("t1_done_lat", 32'(dc - s), 32'(DONE_LAT));
    chk("t1_done_ena", 32'(bus.PL_ENA), 32'd0);
    chk("t1_err", 32'(ERR), 32'd0);
    tick();
    chk("t1_busy_after", 32'(BUSY), 32'd0);
    chk("t1_done_count", 32'(done_cnt), 32'd1);
    chk("t1_init_count", 32'(init_cnt), 32'd1);
    chk("t1_init_cyc",   32'(init_cyc - s), 32'd1);
    chk("t1_ready_cyc",  32'(ready_cyc - s), 32'd2);
    check_writes("t1", DEPTH);
`ifdef RAM_PL_VERIFY_EN
    chk("t1_rd_count", 32'(rd_addr.size()), 32'(DEPTH));
    for (int i = 0; i < rd_addr.size(); i++) chk("t1_rd_addr", 32'(rd_addr[i]), 32'(BASE) + 32'(i));
`endif

    // S_VALID toggling every other cycle
    start_load(s);
    stream_words(1'b1, DEPTH);
    wait_done(dc);
    tick();
    check_writes("t2", DEPTH);
    if (wr_cyc.size() == DEPTH) chk("t2_done_after_last_wr", 32'(dc > wr_cyc[DEPTH-1]), 32'd1);
    chk("t2_done_count", 32'(done_cnt), 32'd1);
    chk("t2_err", 32'(ERR), 32'd0);

`ifdef RAM_PL_VERIFY_EN
    // verify with address 0x102 reading back as 0
    corrupt_addr = 20'h102;
    start_load(s);
    stream_words(1'b0, DEPTH);
    wait_done(dc);
    chk("t3_done_lat", 32'(dc - s), 32'(DONE_LAT));
    chk("t3_err_at_done", 32'(ERR), 32'd1);
    tick(); tick(); tick();
    chk("t3_err_sticky", 32'(ERR), 32'd1);
    corrupt_addr = 20'hFFFFF;
    start_load(s);
    chk("t3_err_cleared", 32'(ERR), 32'd0);
    stream_words(1'b0, DEPTH);
    wait_done(dc);
    chk("t3_err_clean_load", 32'(ERR), 32'd0);
    tick();
`endif

    // abort in the cycle after the 2nd handshake, with a 3rd word offered
    start_load(s);
    stream_words(1'b0, 2);
    ABORT = 1'b1;
    bus.S_VALID = 1'b1;
    bus.S_DATA  = 32'd3;
    tick();
    ABORT = 1'b0;
    bus.S_VALID = 1'b0;
    chk("t4_busy", 32'(BUSY), 32'd0);
    chk("t4_ena",  32'(bus.PL_ENA), 32'd0);
    chk("t4_wen",  32'(bus.PL_WEN), 32'd0);
    chk("t4_err",  32'(ERR), 32'd1);
    tick(); tick(); tick();
    chk("t4_no_done",   32'(done_cnt), 32'd0);
    chk("t4_wr_count",  32'(wr_addr.size()), 32'd2);
    chk("t4_err_sticky", 32'(ERR), 32'd1);
    start_load(s);
    chk("t4_err_cleared", 32'(ERR), 32'd0);
    stream_words(1'b0, DEPTH);
    wait_done(dc);
    tick();
    check_writes("t4b", DEPTH);

    // reset pulse in the middle of WRITE
    start_load(s);
    stream_words(1'b0, 2);
    bus.S_VALID = 1'b1;
    RESET_N = 1'b0;
    tick();
    check_idle_outputs("t5_rst");
    chk("t5_rst_err", 32'(ERR), 32'd0);
    RESET_N = 1'b1;
    bus.S_VALID = 1'b0;
    tick();

    // START held high through the whole load is only taken once
    clear_logs();
    START = 1'b1;
    s = cyc;
    tick();
    stream_words(1'b0, DEPTH);
    START = 1'b0;
    wait_done(dc);
    chk("t6_done_lat", 32'(dc - s), 32'(DONE_LAT));
    tick();
    chk("t6_init_count", 32'(init_cnt), 32'd1);
    check_writes("t6", DEPTH);

    chk("wen_ren_exclusive", 32'(excl_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_pl_loader.md
# ram_pl_loader

Single-clock initiator for the RAM block's PL (preload) port. It accepts a stream of 32-bit words over a valid/ready handshake and writes them into consecutive RAM locations through PL_INIT/PL_ENA/PL_WEN/PL_ADDR/PL_DATA_IN. An optional pass reads the locations back over PL_REN/PL_DATA_OUT and checks them against a write-side checksum. It sits between the configuration/boot fabric and one RAM instance, and drives the side the RAM otherwise ties to 0.

## Interface
- DEPTH, 512: words per load, legal range 1..1024
- BASE_ADDR, 20'h0: PL_ADDR of the first word
- CLK in 1: single clock; the RAM's PL_CLK is driven from this same net
- RESET_N in 1: synchronous, active-low reset
- START in 1: begin a load; sampled only in IDLE
- ABORT in 1: terminate the load from any non-IDLE state
- S_DATA in 32: load word
- S_VALID in 1: S_DATA valid
- S_READY out 1: loader accepts S_DATA this cycle
- BUSY out 1: high in every state except IDLE
- DONE out 1: one-cycle pulse at load end
- ERR out 1: sticky; set on abort or verify mismatch; cleared when START is accepted
- PL_INIT out 1: one-cycle init strobe to the RAM
- PL_ENA out 1: PL port enable
- PL_WEN out 1: PL write strobe
- PL_REN out 1: PL read strobe
- PL_ADDR out 20: PL address
- PL_DATA_IN out 32: PL write data
- PL_DATA_OUT in 32: PL read data, valid 1 cycle after PL_REN

## Operation
- States: IDLE, INIT, WRITE, DRAIN, VERIFY, DONE.
- **IDLE**
  - START=1: go to INIT, clear ERR, clear idx, clear sum.
- **INIT**
  - Lasts exactly 1 cycle with PL_INIT=1 and PL_ENA=1.
  - Then go to WRITE.
- **WRITE**
  - S_READY=1.
  - Handshake (S_VALID & S_READY): register PL_WEN=1, PL_ADDR=BASE_ADDR+idx, PL_DATA_IN=S_DATA for the next cycle.
  - sum += S_DATA, modulo 2^32.
  - idx increments.
  - When the handshake at idx==DEPTH-1 occurs, S_READY drops in the following cycle and the state goes to DRAIN.
- **DRAIN**
  - Lasts 1 cycle and carries the last PL_WEN.
  - Then go to VERIFY if it is compiled in, else to DONE.
- **VERIFY**
  - Clear idx and the read sum.
  - Issue PL_REN=1 with PL_ADDR=BASE_ADDR+idx once per cycle for DEPTH cycles.
  - Add PL_DATA_OUT to the read sum in the cycle after each PL_REN.
  - After the last returned word, compare the two sums; mismatch sets ERR.
  - Then go to DONE.
- **DONE**
  - Lasts 1 cycle with DONE=1 and PL_ENA=0.
  - Then go to IDLE.
- PL_ENA=1 in INIT, WRITE, DRAIN and VERIFY only.
- PL_WEN and PL_REN are never both high.
- PL_ADDR arithmetic is 20-bit. BASE_ADDR+DEPTH-1 must not exceed 20'hFFFFF; wrap is undefined use.
- ABORT (any non-IDLE state):
  - Next cycle: IDLE, ERR=1, all PL outputs 0, no DONE pulse.
  - An in-flight S handshake in the same cycle is discarded.
- START while BUSY is ignored.
- S_VALID outside WRITE is ignored, with S_READY=0.

## Timing
- Reset values: S_READY=0, BUSY=0, DONE=0, ERR=0, PL_INIT=0, PL_ENA=0, PL_WEN=0, PL_REN=0, PL_ADDR=0, PL_DATA_IN=0. State=IDLE, idx=0, sums=0.
- Reset mid-load behaves identically to power-on reset; ERR is not set by reset.
- All outputs are registered.
- START accepted at cycle t: PL_INIT at t+1; S_READY first high at t+2.
- Handshake at cycle c: PL_WEN at c+1.
- With S_VALID held high, one word is written per cycle; total load latency without verify is DEPTH+4 cycles from START to the DONE pulse.
- Verify adds DEPTH+1 cycles.
- S_READY does not depend combinationally on S_VALID.

## Configuration
- RAM_PL_VERIFY_EN defined:
  - VERIFY state, read-sum accumulator and compare are built.
  - PL_REN is driven per the Operation section.
- RAM_PL_VERIFY_EN undefined:
  - DRAIN goes directly to DONE.
  - PL_REN is tied to 0, PL_DATA_OUT is unused.
  - ERR is set only by ABORT.

## Test plan
- DEPTH=4, BASE_ADDR=20'h100, START then words 1,2,3,4 on consecutive cycles, verify off -> PL_INIT one cycle; PL_WEN at addresses 100..103 with data 1..4; DONE 8 cycles after START; ERR=0.
- Same load with S_VALID toggling every other cycle -> each word still lands at the next address in order; no write occurs without a handshake; DONE only after the 4th write.
- Verify on, RAM model echoes written data -> PL_REN at addresses 100..103, sums both 10, ERR=0, DONE at START+13.
- Verify on, RAM model corrupts address 102 to 0 -> read sum 7 vs 10, ERR=1 with DONE pulse; ERR stays 1 until the next START.
- ABORT asserted after the 2nd handshake -> next cycle BUSY=0, PL_ENA=0, ERR=1, no DONE, no 3rd write; a subsequent START clears ERR.
- RESET_N low for 1 cycle mid-WRITE -> all outputs at reset values next cycle; a START pulse while BUSY is ignored.
